// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single-port, synchronous-read data memory.
// CPU has priority; a bounded streak counter guarantees DMA forward progress.
module dmem_arbiter #(
  parameter int ADDR_WIDTH     = 14,
  parameter int DATA_WIDTH     = 32,
  parameter int MAX_CPU_STREAK = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  // CPU requester
  input  logic                  cpu_req_valid,
  output logic                  cpu_req_ready,
  input  logic [ADDR_WIDTH-1:0] cpu_req_addr,
  input  logic [DATA_WIDTH-1:0] cpu_req_wdata,
  input  logic [3:0]            cpu_req_we,
  output logic                  cpu_resp_valid,
  output logic [DATA_WIDTH-1:0] cpu_resp_rdata,
  // DMA / bootloader requester
  input  logic                  dma_req_valid,
  output logic                  dma_req_ready,
  input  logic [ADDR_WIDTH-1:0] dma_req_addr,
  input  logic [DATA_WIDTH-1:0] dma_req_wdata,
  input  logic [3:0]            dma_req_we,
  output logic                  dma_resp_valid,
  output logic [DATA_WIDTH-1:0] dma_resp_rdata,
  // DMEM port
  output logic                  mem_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  output logic [3:0]            mem_we,
  input  logic [DATA_WIDTH-1:0] mem_dout
);

  typedef enum logic {
    OWNER_CPU = 1'b0,
    OWNER_DMA = 1'b1
  } owner_e;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_CPU_STREAK);

  logic [3:0] streak;
  logic       resp_pend;
  owner_e     resp_owner;

  logic dma_turn;
  logic grant_cpu;
  logic grant_dma;
  logic read_fire;

  // DMA wins a tie only once the CPU has used up its streak allowance.
  assign dma_turn  = (streak == STREAK_MAX);
  assign grant_cpu = cpu_req_valid && !(dma_req_valid && dma_turn);
  assign grant_dma = dma_req_valid && !grant_cpu;

  assign cpu_req_ready = grant_cpu;
  assign dma_req_ready = grant_dma;

  assign read_fire = (grant_cpu && (cpu_req_we == 4'b0000)) ||
                     (grant_dma && (dma_req_we == 4'b0000));

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    mem_en   = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    mem_we   = 4'b0000;
    if (grant_cpu) begin
      mem_en   = 1'b1;
      mem_addr = cpu_req_addr;
      mem_din  = cpu_req_wdata;
      mem_we   = cpu_req_we;
    end else if (grant_dma) begin
      mem_en   = 1'b1;
      mem_addr = dma_req_addr;
      mem_din  = dma_req_wdata;
      mem_we   = dma_req_we;
    end
  end

  // NOTE: sequential state uses non-blocking assignments and resets asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      streak     <= 4'd0;
      resp_pend  <= 1'b0;
      resp_owner <= OWNER_CPU;
    end else begin
      if (!dma_req_valid || grant_dma) begin
        streak <= 4'd0;
      end else if (grant_cpu && (streak != STREAK_MAX)) begin
        streak <= streak + 4'd1;
      end

      resp_pend <= read_fire;
      if (read_fire) begin
        resp_owner <= grant_dma ? OWNER_DMA : OWNER_CPU;
      end
    end
  end

  // Read data is steered to whichever requester issued the read last cycle.
  assign cpu_resp_valid = resp_pend && (resp_owner == OWNER_CPU);
  assign dma_resp_valid = resp_pend && (resp_owner == OWNER_DMA);
  assign cpu_resp_rdata = cpu_resp_valid ? mem_dout : '0;
  assign dma_resp_rdata = dma_resp_valid ? mem_dout : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural DMEM plus a rule-level reference model,
// directed scenarios followed by randomized traffic.
module tb_dmem_arbiter;

  localparam int AW  = 14;
  localparam int DW  = 32;
  localparam int MAX = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cpu_req_valid = 1'b0, dma_req_valid = 1'b0;
  logic          cpu_req_ready, dma_req_ready;
  logic [AW-1:0] cpu_req_addr = '0, dma_req_addr = '0;
  logic [DW-1:0] cpu_req_wdata = '0, dma_req_wdata = '0;
  logic [3:0]    cpu_req_we = '0, dma_req_we = '0;
  logic          cpu_resp_valid, dma_resp_valid;
  logic [DW-1:0] cpu_resp_rdata, dma_resp_rdata;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [3:0]    mem_we;
  logic [DW-1:0] mem_dout = '0;

  dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_CPU_STREAK(MAX)) dut (
    .clk(clk), .rst(rst),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
    .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata), .cpu_req_we(cpu_req_we),
    .cpu_resp_valid(cpu_resp_valid), .cpu_resp_rdata(cpu_resp_rdata),
    .dma_req_valid(dma_req_valid), .dma_req_ready(dma_req_ready),
    .dma_req_addr(dma_req_addr), .dma_req_wdata(dma_req_wdata), .dma_req_we(dma_req_we),
    .dma_resp_valid(dma_resp_valid), .dma_resp_rdata(dma_resp_rdata),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
    .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                          input logic [DW-1:0] new_w,
                                          input logic [3:0] be);
    logic [DW-1:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  // Behavioural synchronous-read block RAM driven by the DUT.
  logic [DW-1:0] dmem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we != 4'b0000) dmem[mem_addr] <= merge(dmem[mem_addr], mem_din, mem_we);
      else                   mem_dout <= dmem[mem_addr];
    end
  end

  // Reference model state
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  int            cpu_run;
  bit            ref_pend;
  bit            ref_owner_dma;
  logic [DW-1:0] ref_rdata;
  bit            cpu_fired, dma_fired;
  byte           last_grant;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: inputs are already set after a negedge. Checks the
  // combinational grant and the response due this cycle, then advances.
  task automatic step();
    bit            g_cpu, g_dma, nxt_pend, nxt_owner;
    logic [DW-1:0] nxt_rdata;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    logic [3:0]    we;
    #1;
    g_cpu = cpu_req_valid && !(dma_req_valid && cpu_run >= MAX);
    g_dma = dma_req_valid && !g_cpu;
    a  = g_cpu ? cpu_req_addr  : (g_dma ? dma_req_addr  : '0);
    wd = g_cpu ? cpu_req_wdata : (g_dma ? dma_req_wdata : '0);
    we = g_cpu ? cpu_req_we    : (g_dma ? dma_req_we    : '0);
    check("cpu_req_ready", 64'(cpu_req_ready), 64'(g_cpu));
    check("dma_req_ready", 64'(dma_req_ready), 64'(g_dma));
    check("mem_en",   64'(mem_en),   64'(g_cpu || g_dma));
    check("mem_we",   64'(mem_we),   64'(we));
    check("mem_addr", 64'(mem_addr), 64'(a));
    check("mem_din",  64'(mem_din),  64'(wd));
    check("cpu_resp_valid", 64'(cpu_resp_valid), 64'(ref_pend && !ref_owner_dma));
    check("dma_resp_valid", 64'(dma_resp_valid), 64'(ref_pend && ref_owner_dma));
    check("cpu_resp_rdata", 64'(cpu_resp_rdata), 64'((ref_pend && !ref_owner_dma) ? ref_rdata : '0));
    check("dma_resp_rdata", 64'(dma_resp_rdata), 64'((ref_pend && ref_owner_dma) ? ref_rdata : '0));
    nxt_pend  = (g_cpu || g_dma) && (we == 4'b0000);
    nxt_owner = g_dma;
    nxt_rdata = ref_mem[a];
    @(posedge clk);
    if ((g_cpu || g_dma) && we != 4'b0000) ref_mem[a] = merge(ref_mem[a], wd, we);
    if (nxt_pend) begin
      ref_owner_dma = nxt_owner;
      ref_rdata     = nxt_rdata;
    end
    ref_pend = nxt_pend;
    if (!dma_req_valid || g_dma) cpu_run = 0;
    else if (g_cpu)              cpu_run++;
    cpu_fired  = g_cpu;
    dma_fired  = g_dma;
    last_grant = g_cpu ? "C" : (g_dma ? "D" : "-");
    @(negedge clk);
  endtask

  task automatic set_cpu(input bit v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [3:0] we);
    cpu_req_valid = v; cpu_req_addr = a; cpu_req_wdata = d; cpu_req_we = we;
  endtask

  task automatic set_dma(input bit v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [3:0] we);
    dma_req_valid = v; dma_req_addr = a; dma_req_wdata = d; dma_req_we = we;
  endtask

  string exp_seq;
  string got_seq;

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      dmem[i]    = 32'hA5000000 | i;
      ref_mem[i] = 32'hA5000000 | i;
    end
    dmem[14'h010] = 32'hDEADBEEF;  ref_mem[14'h010] = 32'hDEADBEEF;
    dmem[14'h030] = 32'h11223344;  ref_mem[14'h030] = 32'h11223344;
    cpu_run = 0; ref_pend = 0; ref_owner_dma = 0; ref_rdata = '0;

    // Reset state
    #12;
    check("rst cpu_resp_valid", 64'(cpu_resp_valid), 64'd0);
    check("rst dma_resp_valid", 64'(dma_resp_valid), 64'd0);
    check("rst mem_en", 64'(mem_en), 64'd0);
    check("rst mem_we", 64'(mem_we), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    step();

    // CPU-only read
    set_cpu(1, 14'h010, '0, 4'h0);
    step();
    check("cpu read fired", 64'(cpu_fired), 64'd1);
    set_cpu(0, '0, '0, 4'h0);
    check("cpu read data", 64'(cpu_resp_rdata), 64'hDEADBEEF);
    check("cpu read valid", 64'(cpu_resp_valid), 64'd1);
    check("dma no resp", 64'(dma_resp_valid), 64'd0);
    step();

    // Contention, all reads
    exp_seq = "CCCCDCCCCD";
    got_seq = "";
    set_cpu(1, 14'h100, '0, 4'h0);
    set_dma(1, 14'h200, '0, 4'h0);
    for (int i = 0; i < 10; i++) begin
      step();
      got_seq = {got_seq, string'(last_grant)};
      if (cpu_fired) cpu_req_addr = cpu_req_addr + 1;
      if (dma_fired) dma_req_addr = dma_req_addr + 1;
    end
    n_checks++;
    assert (got_seq == exp_seq) else begin
      n_errors++;
      $error("FAIL grant_seq: observed %s expected %s", got_seq, exp_seq);
    end
    set_cpu(0, '0, '0, 4'h0);
    set_dma(0, '0, '0, 4'h0);
    step();

    // DMA write then CPU read of the same word
    set_dma(1, 14'h020, 32'h12345678, 4'hF);
    step();
    set_dma(0, '0, '0, 4'h0);
    check("dma write no resp", 64'(dma_resp_valid), 64'd0);
    set_cpu(1, 14'h020, '0, 4'h0);
    step();
    set_cpu(0, '0, '0, 4'h0);
    check("raw cpu rdata", 64'(cpu_resp_rdata), 64'h12345678);
    step();

    // Byte write into a known word, then read it back
    set_cpu(1, 14'h030, 32'h0000AB00, 4'b0010);
    step();
    set_cpu(1, 14'h030, '0, 4'h0);
    step();
    set_cpu(0, '0, '0, 4'h0);
    check("byte write merge", 64'(cpu_resp_rdata), 64'h1122AB44);
    step();

    // Streak restarts when DMA drops its request for one cycle
    got_seq = "";
    set_cpu(1, 14'h040, '0, 4'h0);
    set_dma(1, 14'h050, '0, 4'h0);
    for (int i = 0; i < 3; i++) begin step(); got_seq = {got_seq, string'(last_grant)}; end
    dma_req_valid = 1'b0;
    step(); got_seq = {got_seq, string'(last_grant)};
    dma_req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin step(); got_seq = {got_seq, string'(last_grant)}; end
    n_checks++;
    assert (got_seq == "CCCCCCCCD") else begin
      n_errors++;
      $error("FAIL streak_restart: observed %s expected CCCCCCCCD", got_seq);
    end
    set_cpu(0, '0, '0, 4'h0);
    set_dma(0, '0, '0, 4'h0);
    step();

    // Async reset between a read fire and its response
    set_cpu(1, 14'h010, '0, 4'h0);
    #1;
    check("pre-reset ready", 64'(cpu_req_ready), 64'd1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("reset drops resp", 64'(cpu_resp_valid), 64'd0);
    check("reset rdata zero", 64'(cpu_resp_rdata), 64'd0);
    set_cpu(0, '0, '0, 4'h0);
    ref_pend = 0; cpu_run = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("post-reset mem_en", 64'(mem_en), 64'd0);
    check("post-reset cpu_resp", 64'(cpu_resp_valid), 64'd0);
    check("post-reset dma_resp", 64'(dma_resp_valid), 64'd0);
    @(negedge clk);
    step();

    // Randomized traffic on a small address window to exercise RAW hazards
    for (int i = 0; i < 400; i++) begin
      if (!cpu_req_valid || cpu_fired)
        set_cpu($urandom_range(0, 3) != 0, AW'($urandom_range(0, 15)), $urandom,
                ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0);
      if (!dma_req_valid || dma_fired)
        set_dma($urandom_range(0, 3) != 0, AW'($urandom_range(0, 15)), $urandom,
                ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0);
      step();
    end
    set_cpu(0, '0, '0, 4'h0);
    set_dma(0, '0, '0, 4'h0);
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port, synchronous-read data memory (DMEM) between two requesters: the CPU memory stage and a DMA/bootloader port that bulk-loads or inspects memory.
- Sits between the CPU pipeline and the DMEM block RAM.
- Arbitration uses CPU-preferred priority with a bounded-starvation counter so DMA always makes progress.
- Read responses are routed back to the requester that issued them, one cycle after acceptance.

Parameters:
- ADDR_WIDTH, 14, word-address width of DMEM (16384 words).
- DATA_WIDTH, 32, data width.
- MAX_CPU_STREAK, 4, max consecutive CPU grants while DMA waits; range 1..15.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- cpu_req_valid  input  1  CPU request present.
- cpu_req_ready  output  1  CPU request accepted this cycle.
- cpu_req_addr  input  ADDR_WIDTH  CPU word address.
- cpu_req_wdata  input  DATA_WIDTH  CPU write data.
- cpu_req_we  input  4  CPU byte write enables; 0 = read.
- cpu_resp_valid  output  1  CPU read data valid.
- cpu_resp_rdata  output  DATA_WIDTH  CPU read data.
- dma_req_valid, dma_req_ready, dma_req_addr, dma_req_wdata, dma_req_we, dma_resp_valid, dma_resp_rdata: same as the CPU ports, for the DMA requester.
- mem_en  output  1  DMEM access enable.
- mem_addr  output  ADDR_WIDTH  DMEM address.
- mem_din  output  DATA_WIDTH  DMEM write data.
- mem_we  output  4  DMEM byte write enables.
- mem_dout  input  DATA_WIDTH  DMEM read data; valid the cycle after a read with mem_en=1.

Behaviour:
- Handshake: a transfer fires when valid && ready in the same cycle. A requester holds addr/wdata/we stable and keeps valid high until it fires. ready is combinational from the valids and the streak counter; no valid→ready dependency on the other requester's ready.
- Grant selection, per cycle:
  - Neither valid: no grant, mem_en=0, mem_we=0.
  - One valid: that requester is granted.
  - Both valid: CPU is granted unless streak==MAX_CPU_STREAK, in which case DMA is granted.
- At most one ready is high per cycle.
- mem_en=1 exactly when a grant occurs. mem_addr, mem_din and mem_we mux combinationally from the granted requester. When there is no grant, mem_we=0 and mem_addr/mem_din are don't-care (drive 0).
- streak counter (4-bit):
  - Increments on a CPU grant while dma_req_valid=1.
  - Clears to 0 on a DMA grant, or on any cycle where dma_req_valid=0.
  - Saturates at MAX_CPU_STREAK.
- Response path:
  - On a read fire (we==0), registered tag resp_owner = granted requester and resp_pend=1.
  - Next cycle, the owner's resp_valid=1 and its resp_rdata = mem_dout. The other requester's resp_valid=0 and its rdata=0.
  - Write fires produce no response.
- Back-to-back reads are fully pipelined: one accepted per cycle, and each response follows its own request by exactly 1 cycle regardless of interleaving.
- Simultaneous cases:
  - A read response to one requester and a new grant to the other in the same cycle are independent and both allowed.
  - A write fire followed next cycle by a read to the same address returns the new data (DMEM write-first or read-after-write ordering is guaranteed by the 1-cycle sequencing).
- Reset (rst=0, asynchronous), takes effect immediately regardless of clk:
  - streak=0, resp_pend=0.
  - cpu_resp_valid=0, dma_resp_valid=0, both rdata outputs 0.
  - Any in-flight read response is dropped and not delivered after reset release.
  - ready and mem_* outputs follow the combinational rules; with both valids low, mem_en=0 and mem_we=0.
- Latency: request to memory is 0 cycles (combinational). Read data to requester is 1 cycle after fire.

Test Plan:
- CPU only, no DMA: CPU reads addr 0x010 holding 0xDEADBEEF → cpu_req_ready=1 same cycle, cpu_resp_valid=1 with rdata 0xDEADBEEF next cycle; dma_resp_valid stays 0.
- Contention, both valid continuously, MAX_CPU_STREAK=4, all reads → grant sequence C,C,C,C,D,C,C,C,C,D; each response goes to the correct owner 1 cycle after its grant.
- DMA writes 0x12345678 to 0x020 with we=4'hF, then CPU reads 0x020 the next cycle → cpu_resp_rdata=0x12345678; no response pulse for the write.
- Byte write: CPU we=4'b0010 with wdata 0x0000AB00 to a word holding 0x11223344 → later read returns 0x1122AB44.
- Streak reset: CPU granted 3 times, then dma_req_valid drops for 1 cycle and reasserts → counter restarts at 0, so DMA waits another 4 CPU grants.
- Async reset asserted mid-cycle between a read fire and its response → resp_valid never asserts for that read. After release with both valids low, mem_en=0 and both resp_valid=0.
